// File: rtl/wrr_mem_arbiter_if.sv
// Request/grant bundle between the PE requesters, the memory controller and the arbiter.
// The arbiter uses the slave modport.
interface wrr_mem_arbiter_if #(
  parameter int unsigned NUM_REQ  = 10,
  parameter int unsigned WEIGHT_W = 3
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic [NUM_REQ-1:0]          lock;
  logic                        ack;
  logic [NUM_REQ-1:0]          gnt;
  logic                        gnt_valid;
  logic [IdW-1:0]              gnt_id;

  modport master (output req, weight, lock, ack, input gnt, gnt_valid, gnt_id);
  modport slave  (input req, weight, lock, ack, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/wrr_mem_arbiter.sv
// Weighted round-robin arbiter for the shared-memory port: registered one-hot grant,
// per-turn burst credit, lock for atomic sequences, same-cycle re-arbitration on release.
module wrr_mem_arbiter #(
  parameter int unsigned NUM_REQ  = 10,
  parameter int unsigned WEIGHT_W = 3,
  parameter int unsigned LOCK_MAX = 15
) (
  input logic              clk,
  input logic              rst,
  wrr_mem_arbiter_if.slave bus
);
  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      owner_q, owner_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [CntW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;

  logic [IdW-1:0]      nxt_ptr, arb_ptr, arb_idx, idx_m, idx_u, grant_idx;
  logic [NUM_REQ-1:0]  arb_req, arb_masked;
  logic                arb_valid, any_m, do_grant;
  logic                own_req, own_lock, lock_ok, keep_on_ack;
  logic [WEIGHT_W-1:0] wfield;

  assign nxt_ptr  = (owner_q == IdW'(NUM_REQ - 1)) ? '0 : owner_q + IdW'(1);
  assign own_req  = bus.req[owner_q];
  assign own_lock = bus.lock[owner_q];
  // lock_cnt includes the ack being taken, so a locked turn ends after LOCK_MAX acks.
  assign lock_ok     = own_lock && ((32'(lock_cnt_q) + 32'd1) < LOCK_MAX);
  assign keep_on_ack = own_req && ((credit_q > WEIGHT_W'(1)) || lock_ok);

  // Candidates: in OWN the old owner is masked out and the search starts just past it.
  always_comb begin
    arb_ptr = ptr_q;
    arb_req = bus.req;
    if (state_q == StOwn) begin
      arb_ptr = nxt_ptr;
      arb_req[owner_q] = 1'b0;
    end
  end

  // Masked/unmasked priority pair; the downward scan leaves the lowest set index.
  always_comb begin
    arb_masked = '0;
    idx_m      = '0;
    idx_u      = '0;
    any_m      = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      arb_masked[i] = arb_req[i] && (i >= int'(arb_ptr));
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (arb_masked[i]) begin
        idx_m = IdW'(i);
        any_m = 1'b1;
      end
      if (arb_req[i]) idx_u = IdW'(i);
    end
  end

  assign arb_idx   = any_m ? idx_m : idx_u;
  assign arb_valid = |arb_req;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    lock_cnt_d = lock_cnt_q;
    do_grant   = 1'b0;
    grant_idx  = arb_idx;
    unique case (state_q)
      StIdle: do_grant = arb_valid;
      StOwn: begin
        if (bus.ack && keep_on_ack) begin
          credit_d = (credit_q != '0) ? credit_q - WEIGHT_W'(1) : '0;
          if (own_lock && (32'(lock_cnt_q) < LOCK_MAX)) lock_cnt_d = lock_cnt_q + CntW'(1);
        end else if (bus.ack || !own_req) begin
          ptr_d = nxt_ptr;
          if (arb_valid) begin
            do_grant = 1'b1;
          end else if (own_req) begin
            do_grant  = 1'b1;
            grant_idx = owner_q;
          end else begin
            state_d = StIdle;
            owner_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    wfield = bus.weight[int'(grant_idx) * int'(WEIGHT_W) +: WEIGHT_W];
    if (do_grant) begin
      state_d    = StOwn;
      owner_d    = grant_idx;
      credit_d   = (wfield == '0) ? WEIGHT_W'(1) : wfield;
      lock_cnt_d = '0;
    end

    gnt_d = '0;
    if (state_d == StOwn) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      ptr_q      <= '0;
      credit_q   <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = owner_q;
endmodule

// File: tb/tb_wrr_mem_arbiter.sv
// Bench for wrr_mem_arbiter: directed scenarios then randomized traffic, all checked
// against a turn-level reference model of the arbitration rules.
module tb_wrr_mem_arbiter;
  localparam int N  = 10;
  localparam int W  = 3;
  localparam int LM = 15;
  localparam int NW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wrr_mem_arbiter_if #(.NUM_REQ(N), .WEIGHT_W(W)) bus ();

  wrr_mem_arbiter #(.NUM_REQ(N), .WEIGHT_W(W), .LOCK_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 idle), scan start, credits left, locked acks taken.
  int m_owner, m_ptr, m_credit, m_lcnt;

  int exp2[5] = '{1, 2, 3, 0, 1};
  int exp3[7] = '{2, 2, 2, 3, 2, 2, 2};

  function automatic int m_pick(int start, int skip);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (bus.req[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  function automatic int m_weight(int i);
    int w;
    w = int'(bus.weight[i*W +: W]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_credit = 0;
    m_lcnt   = 0;
  endtask

  task automatic model_grant(int w);
    m_owner  = w;
    m_credit = m_weight(w);
    m_lcnt   = 0;
  endtask

  task automatic model_step();
    int w, o;
    bit held, lk;
    if (!rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = m_pick(m_ptr, -1);
      if (w >= 0) model_grant(w);
    end else begin
      o    = m_owner;
      held = bus.req[o];
      lk   = bus.lock[o];
      if (bus.ack && held && (m_credit > 1 || (lk && m_lcnt + 1 < LM))) begin
        m_credit = (m_credit > 0) ? m_credit - 1 : 0;
        if (lk && m_lcnt < LM) m_lcnt++;
      end else if (bus.ack || !held) begin
        m_ptr = (o + 1) % N;
        w = m_pick(m_ptr, o);
        if (w < 0 && held) w = o;
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check({tag, ".gnt"}, 32'(bus.gnt), eg);
    check({tag, ".id"}, 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  // Entered at a negedge; leaves at the following negedge with reset released.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.req    = '1;
    bus.weight = {N{3'd1}};
    bus.lock   = '0;
    bus.ack    = 1'b0;
    model_reset();
    #1 rst = 1'b0;

    // 1: reset held with all requests, then first grant to requester 0
    @(negedge clk);
    repeat (3) tick("t1_hold");
    check("t1_hold_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b1;
    tick("t1_first");
    check("t1_first_gnt", 32'(bus.gnt), 32'h001);
    check("t1_first_id", 32'(bus.gnt_id), 32'd0);

    // 2: back-to-back rotation over 0..3
    bus.req = 10'b0000001111;
    bus.ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t2");
      check("t2_id", 32'(bus.gnt_id), 32'(exp2[i]));
    end

    // 3: weight 3 on requester 2
    do_reset();
    bus.weight = {N{3'd1}};
    bus.weight[2*W +: W] = 3'd3;
    bus.req = 10'b0000001100;
    bus.ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick("t3");
      check("t3_id", 32'(bus.gnt_id), 32'(exp3[i]));
    end

    // 4: lock on requester 5, forced release after LOCK_MAX acks
    do_reset();
    bus.weight = {N{3'd1}};
    bus.lock   = 10'b0000100000;
    bus.req    = 10'b0001100000;
    bus.ack    = 1'b1;
    for (int i = 0; i < LM; i++) begin
      tick("t4_lock");
      check("t4_lock_id", 32'(bus.gnt_id), 32'd5);
    end
    tick("t4_rel");
    check("t4_rel_id", 32'(bus.gnt_id), 32'd6);
    bus.lock = '0;

    // 5: abort by owner 1, then grant to 7 held stable with no ack
    do_reset();
    bus.req = 10'b0000000010;
    bus.ack = 1'b0;
    tick("t5_own1");
    check("t5_own1_id", 32'(bus.gnt_id), 32'd1);
    bus.req = 10'b0010000000;
    tick("t5_abort");
    check("t5_abort_id", 32'(bus.gnt_id), 32'd7);
    for (int i = 0; i < 20; i++) begin
      tick("t5_hold");
      check("t5_hold_gnt", 32'(bus.gnt), 32'h080);
    end

    // 6: owner 3 mid-burst with ptr advanced, async reset, ptr back to 0
    bus.weight[3*W +: W] = 3'd7;
    bus.req = 10'b0000001000;
    tick("t6_own3");
    check("t6_own3_id", 32'(bus.gnt_id), 32'd3);
    bus.ack = 1'b1;
    tick("t6_burst");
    bus.ack = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
    check("t6_rst_valid", 32'(bus.gnt_valid), 32'd0);
    bus.req = 10'b1000001000;
    @(negedge clk);
    rst = 1'b1;
    tick("t6_after");
    check("t6_after_id", 32'(bus.gnt_id), 32'd3);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.weight = NW'($urandom);
      if ($urandom_range(0, 15) == 0) bus.lock = N'($urandom & $urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
